// File: rtl/bird_pkg.sv
// Shared constants and types for the bird column, pipe scroller and display mux.
package bird_pkg;

    localparam int unsigned BIRD_ROWS     = 8;
    localparam int unsigned BIRD_FALL_DIV = 4;
    localparam int unsigned SCORE_W       = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_OVER
    } bird_state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flap_latch.sv
// Button edge detector with a pending-flap latch held until a tick consumes it.
module flap_latch (
    input  logic clk,
    input  logic reset,
    input  logic flap,
    input  logic consume,
    output logic pend
);

    logic flap_q;
    logic pend_q;
    logic rise_c;

    assign rise_c = flap & ~flap_q;

    // A same-cycle edge is visible immediately so a coincident tick can consume it.
    assign pend = pend_q | rise_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            flap_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            flap_q <= flap;
            pend_q <= pend & ~consume;
        end
    end

endmodule

// File: rtl/bird_ctrl.sv
// Bird column controller: position, gravity timing, collision, game state and score.
module bird_ctrl
    import bird_pkg::*;
#(
    parameter int unsigned ROWS      = BIRD_ROWS,
    parameter int unsigned FALL_DIV  = BIRD_FALL_DIV,
    parameter int unsigned START_ROW = ROWS / 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               flap,
    input  logic [ROWS-1:0]    pipe_col,
    input  logic               pass,
    output logic [ROWS-1:0]    bird_row,
    output logic               playing,
    output logic               over,
    output logic [SCORE_W-1:0] score
);

    localparam int unsigned POS_W  = cnt_width(ROWS);
    localparam int unsigned FALL_W = cnt_width(FALL_DIV);

    localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(ROWS - 1);
    localparam logic [POS_W-1:0]  POS_START = POS_W'(START_ROW);
    localparam logic [FALL_W-1:0] FALL_MAX  = FALL_W'(FALL_DIV - 1);

    bird_state_t        state_q;
    logic [POS_W-1:0]   pos_q;
    logic [FALL_W-1:0]  fall_q;
    logic [ROWS-1:0]    bird_row_q;
    logic               playing_q;
    logic               over_q;
    logic [SCORE_W-1:0] score_q;

    logic pend_c;
    logic consume_c;
    logic hit_c;

    // IDLE always swallows the start flap; PLAY consumes on each tick.
    assign consume_c = (state_q == S_IDLE) || ((state_q == S_PLAY) && tick);
    assign hit_c     = |(bird_row_q & pipe_col);

    flap_latch u_flap_latch (
        .clk     (clk),
        .reset   (reset),
        .flap    (flap),
        .consume (consume_c),
        .pend    (pend_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pos_q      <= POS_START;
            fall_q     <= '0;
            bird_row_q <= ROWS'(1) << START_ROW;
            playing_q  <= 1'b0;
            over_q     <= 1'b0;
            score_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pend_c) begin
                        state_q   <= S_PLAY;
                        playing_q <= 1'b1;
                    end
                end

                S_PLAY: begin
                    if (pass && (score_q != '1)) begin
                        score_q <= score_q + SCORE_W'(1);
                    end

                    // Collision wins over a same-cycle tick and freezes motion.
                    if (hit_c) begin
                        state_q   <= S_OVER;
                        playing_q <= 1'b0;
                        over_q    <= 1'b1;
                    end else if (tick) begin
                        if (pend_c) begin
                            fall_q <= '0;
                            if (pos_q != POS_MAX) begin
                                pos_q      <= pos_q + POS_W'(1);
                                bird_row_q <= bird_row_q << 1;
                            end
                        end else if (fall_q == FALL_MAX) begin
                            fall_q <= '0;
                            if (pos_q != '0) begin
                                pos_q      <= pos_q - POS_W'(1);
                                bird_row_q <= bird_row_q >> 1;
                            end
                        end else begin
                            fall_q <= fall_q + FALL_W'(1);
                        end
                    end
                end

                S_OVER: begin
                end

                default: begin
                    state_q   <= S_IDLE;
                    playing_q <= 1'b0;
                    over_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bird_row = bird_row_q;
    assign playing  = playing_q;
    assign over     = over_q;
    assign score    = score_q;

endmodule

// File: tb/tb_bird_ctrl.sv
// Scoreboard bench for bird_ctrl: a game-rule model queues expectations, a monitor compares.
module tb_bird_ctrl;

    localparam int ROWS     = 8;
    localparam int FALL_DIV = 4;
    localparam int START    = ROWS / 2;

    typedef struct {
        logic [7:0] row;
        logic       playing;
        logic       over;
        logic [7:0] score;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       flap;
    logic [7:0] pipe_col;
    logic       pass;
    logic [7:0] bird_row;
    logic       playing;
    logic       over;
    logic [7:0] score;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Game model: 0 = waiting to start, 1 = in flight, 2 = crashed.
    int m_mode, m_pos, m_fall, m_score;
    bit m_pend, m_prev;

    always #5 clk = ~clk;

    bird_ctrl u_dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .flap     (flap),
        .pipe_col (pipe_col),
        .pass     (pass),
        .bird_row (bird_row),
        .playing  (playing),
        .over     (over),
        .score    (score)
    );

    task automatic chk(input string tag, input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s %s got %0h expected %0h", tag, name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk(mon_e.tag, "bird_row", int'(bird_row), int'(mon_e.row));
            chk(mon_e.tag, "playing",  int'(playing),  int'(mon_e.playing));
            chk(mon_e.tag, "over",     int'(over),     int'(mon_e.over));
            chk(mon_e.tag, "score",    int'(score),    int'(mon_e.score));
        end
    end

    task automatic model_step(input bit r, input bit t, input bit f, input bit p, input logic [7:0] pc);
        if (r) begin
            m_mode = 0; m_pos = START; m_fall = 0; m_score = 0; m_pend = 0; m_prev = 0;
            return;
        end
        if (f && !m_prev) m_pend = 1;
        m_prev = f;
        if (m_mode == 0) begin
            if (m_pend) begin
                m_mode = 1;
                m_pend = 0;
            end
        end else if (m_mode == 1) begin
            if (p) m_score = (m_score < 255) ? m_score + 1 : 255;
            if (pc[m_pos]) begin
                m_mode = 2;
            end else if (t) begin
                if (m_pend) begin
                    m_pos  = (m_pos + 1 > ROWS - 1) ? ROWS - 1 : m_pos + 1;
                    m_fall = 0;
                    m_pend = 0;
                end else begin
                    m_fall++;
                    if (m_fall == FALL_DIV) begin
                        m_fall = 0;
                        m_pos  = (m_pos > 0) ? m_pos - 1 : 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit t, input bit f, input bit p, input logic [7:0] pc);
        exp_t e;
        reset = r; tick = t; flap = f; pass = p; pipe_col = pc;
        model_step(r, t, f, p, pc);
        e.row     = 8'(1 << m_pos);
        e.playing = (m_mode == 1);
        e.over    = (m_mode == 2);
        e.score   = 8'(m_score);
        e.tag     = phase;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic start_game();
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        int guard;
        reset = 1'b1; tick = 1'b0; flap = 1'b0; pass = 1'b0; pipe_col = '0;

        phase = "idle_reset";
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0, 8'h00);
            step(0, 0, 0, 0, 8'h00);
        end

        phase = "start_fall";
        step(0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0, 8'h00);
            step(0, 0, 0, 0, 8'h00);
        end

        phase = "flap_ceiling";
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, 8'h00);
            step(0, 0, 0, 0, 8'h00);
            step(0, 1, 0, 0, 8'h00);
        end
        phase = "flap_held";
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        phase = "collide_on_fall";
        guard = 0;
        while (!(m_pos == 3 && m_fall == FALL_DIV - 1) && guard < 100) begin
            step(0, 1, 0, 0, 8'h00);
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL collide_setup guard got %0d expected below 100", guard);
        end
        step(0, 1, 0, 0, 8'h08);
        phase = "over_frozen";
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1, 1, 8'hFF);
            step(0, 0, 0, 1, 8'h00);
        end

        phase = "score_three";
        start_game();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'h00);
        phase = "score_saturate";
        for (int i = 0; i < 260; i++) step(0, 0, 0, 1, 8'h00);

        phase = "reset_midplay";
        start_game();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'h00);
        step(1, 0, 1, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, i[0], 0, 1, 8'h00);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain queue got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bird_ctrl.md
# bird_ctrl

Controller that sequences the bird column of the Flappy Bird LED-matrix game. It owns the bird's vertical position and the gravity/flap timing, and detects collisions against the obstacle column. It also runs the IDLE/PLAY/OVER game state machine and keeps the score. It replaces the per-LED bit cells with one registered position, and drives the bird column of the display plus the game-over flag used by the rest of the design.

## Interface
Parameters:
- ROWS, 8, height of the bird column; bird position range 0 (bottom) .. ROWS-1 (top)
- FALL_DIV, 4, consecutive non-flap ticks per one-row fall; must be ≥ 1
- START_ROW, ROWS/2, row the bird occupies after reset and during IDLE

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- tick  in  1  one-cycle game-rate enable pulse; all motion happens only on tick cycles
- flap  in  1  raw player button level; synchronous to clk
- pipe_col  in  ROWS  obstacle occupancy of the column the bird sits in; bit r = obstacle at row r
- pass  in  1  one-cycle pulse: a pipe gap has moved past the bird column
- bird_row  out  ROWS  one-hot bird column drive, equal to 1 << pos
- playing  out  1  high in PLAY
- over  out  1  high in OVER
- score  out  8  pipes passed, saturating

## Operation
- Flap edge: register flap_q; edge = flap & ~flap_q. An edge sets flap_pend, which holds until consumed by a tick. If an edge and a tick occur in the same cycle, the edge is consumed in that tick.
- States: S_IDLE, S_PLAY, S_OVER.
- S_IDLE: pos held at START_ROW, fall_cnt = 0.
  - Any flap edge or pending flap → S_PLAY.
  - The start flap is consumed by the transition and causes no upward move.
  - tick is ignored.
- S_PLAY, on a tick cycle:
  - If a flap is pending/edge: pos = min(pos+1, ROWS-1), fall_cnt = 0, clear flap_pend.
  - Otherwise: if fall_cnt == FALL_DIV-1, then pos = max(pos-1, 0) and fall_cnt = 0; else fall_cnt + 1.
  - The floor and ceiling clamp the bird; they do not end the game.
- S_PLAY, every cycle: if (bird_row & pipe_col) != 0 → S_OVER. Collision has priority over a same-cycle tick: pos and fall_cnt freeze.
- S_PLAY: pass increments score, saturating at 255. pass is ignored outside S_PLAY.
- S_OVER: everything is frozen; flap, tick, pass and pipe_col are ignored. Only reset leaves S_OVER.
- Reset, including mid-game: next cycle state = S_IDLE, pos = START_ROW, fall_cnt = 0, flap_q = 0, flap_pend = 0, score = 0.

## Timing
- All outputs are registered.
- Reset values:
  - bird_row = 1 << START_ROW (8'h10 at defaults)
  - playing = 0
  - over = 0
  - score = 0
- Motion latency: a tick sampled at edge n updates bird_row after edge n (visible in cycle n+1).
- Collision latency: overlap present before edge n gives over = 1 and playing = 0 after edge n.
- Start latency: a flap edge sampled at edge n gives playing = 1 after edge n.
- Falling without flaps moves one row per FALL_DIV ticks. The first fall after a flap comes on the FALL_DIV-th tick after it.
- Multiple flap edges between two ticks collapse to a single move.

## Structure
- Package bird_pkg holds:
  - typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} bird_state_t
  - default ROWS and FALL_DIV constants, shared with the pipe scroller and the display mux
- Sub-module flap_latch: edge detect plus pending latch. Ports: clk, reset, flap, consume, pend.
- Position counter, fall counter, FSM and score counter live in bird_ctrl.

## Test plan
- Reset then 10 ticks with no flap → bird_row stays 8'h10; playing = 0, over = 0, score = 0.
- Flap pulse in IDLE → playing = 1 the next cycle with bird_row still 8'h10. Then 4 ticks with no flap → bird_row 8'h08 after the 4th tick; 8 more ticks → 8'h02.
- In PLAY at pos 6, two flap pulses each before a tick → bird_row 8'h80 then stays 8'h80. Hold the button high across ticks → no further moves and no repeated flaps.
- Bird at 8'h08, drive pipe_col = 8'h08 coinciding with a fall tick → over = 1 and bird_row stays 8'h08. Later ticks, flaps and pass leave all outputs unchanged.
- In PLAY, 3 pass pulses → score = 3. 260 pass pulses → score = 255.
- Reset asserted mid-play at pos 2 with score 5 → next cycle bird_row = 8'h10, score = 0, state IDLE. A flap arriving in the reset cycle is ignored.
